// File: rtl/acc_pkg.sv
// Shared types and constants for the accelerator X-interface adapter.
// Holds the scoreboard issue/response payloads, the register-field positions
// of the offloaded instruction, and small field-extraction helpers.
package acc_pkg;

    localparam int unsigned InstrW   = 32;
    localparam int unsigned RegAddrW = 5;
    localparam int unsigned NumRegs  = 32;

    // Bit positions of register fields inside the offloaded instruction
    localparam int unsigned RdLsb  = 7;
    localparam int unsigned Rs1Lsb = 15;
    localparam int unsigned Rs2Lsb = 20;
    localparam int unsigned Rs3Lsb = 27;

    // Issue-side request: destination and which halves of the pair get written
    typedef struct packed {
        logic [RegAddrW-1:0] rd;
        logic [1:0]          writeback;
    } acc_issue_t;

    // Response-side completion: destination and dual-writeback flag
    typedef struct packed {
        logic [RegAddrW-1:0] rd;
        logic                dual;
    } acc_rsp_t;

    function automatic logic [RegAddrW-1:0] reg_field(input logic [InstrW-1:0] instr,
                                                      input int unsigned lsb);
        return instr[lsb +: RegAddrW];
    endfunction

    // Odd partner register of a dual writeback (rd | 1)
    function automatic logic [RegAddrW-1:0] pair_reg(input logic [RegAddrW-1:0] rd);
        return {rd[RegAddrW-1:1], 1'b1};
    endfunction

endpackage

// File: rtl/acc_x_scoreboard.sv
// Pending-writeback scoreboard for the X adapter.
// Ports: clk_i/rst_ni; set_valid_i/set_i mark destinations of an issued
// instruction; clr_valid_i/clr_i release destinations on response handshake;
// instr_i/use_rs_i/writeback_i describe the candidate instruction and
// hazard_o flags a conflict against the registered pending set.
module acc_x_scoreboard
    import acc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              set_valid_i,
    input  acc_issue_t        set_i,
    input  logic              clr_valid_i,
    input  acc_rsp_t          clr_i,
    input  logic [InstrW-1:0] instr_i,
    input  logic [2:0]        use_rs_i,
    input  logic [1:0]        writeback_i,
    output logic              hazard_o
);

    logic [NumRegs-1:0] pending_q;
    logic [NumRegs-1:0] pending_d;

    // Clear first, then set, so both land when they hit different registers
    always_comb begin
        pending_d = pending_q;
        if (clr_valid_i) begin
            pending_d[clr_i.rd] = 1'b0;
            if (clr_i.dual) begin
                pending_d[pair_reg(clr_i.rd)] = 1'b0;
            end
        end
        if (set_valid_i) begin
            if (set_i.writeback[0]) begin
                pending_d[set_i.rd] = 1'b1;
            end
            if (set_i.writeback[1]) begin
                pending_d[pair_reg(set_i.rd)] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Hazard looks only at registered state: a clear is seen one cycle later
    always_comb begin
        hazard_o = (use_rs_i[0]    && pending_q[reg_field(instr_i, Rs1Lsb)])
                || (use_rs_i[1]    && pending_q[reg_field(instr_i, Rs2Lsb)])
                || (use_rs_i[2]    && pending_q[reg_field(instr_i, Rs3Lsb)])
                || (writeback_i[0] && pending_q[reg_field(instr_i, RdLsb)])
                || (writeback_i[1] && pending_q[pair_reg(reg_field(instr_i, RdLsb))]);
    end

endmodule

// File: rtl/acc_x_adapter.sv
// X-interface to C-bus adapter for an offloaded accelerator.
// Ports: clk_i/rst_ni; x_q_* offload request in, x_k_* accept/writeback
// info, x_p_* response out; prd_* predecoder query; c_q_* C-bus request out
// (single held entry), c_p_* C-bus response in (passed straight to x_p_*).
// Build option: define ACC_X_ADAPTER_HAZARD_EN to enable the pending-register
// scoreboard and hazard stall; otherwise no scoreboard is built.
module acc_x_adapter
    import acc_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 2,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned AccAddr   = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [31:0]          x_q_instr_data,
    input  logic [DataWidth-1:0] x_q_rs1,
    input  logic [DataWidth-1:0] x_q_rs2,
    input  logic [DataWidth-1:0] x_q_rs3,
    input  logic [2:0]           x_q_rs_valid,
    input  logic                 x_q_valid,
    output logic                 x_q_ready,
    output logic                 x_k_accept,
    output logic [1:0]           x_k_writeback,
    output logic [DataWidth-1:0] x_p_data0,
    output logic [DataWidth-1:0] x_p_data1,
    output logic                 x_p_dual_writeback,
    output logic                 x_p_error,
    output logic [4:0]           x_p_rd,
    output logic                 x_p_valid,
    input  logic                 x_p_ready,
    output logic [31:0]          prd_q_instr_data,
    input  logic                 prd_p_accept,
    input  logic [1:0]           prd_p_writeback,
    input  logic [2:0]           prd_p_use_rs,
    output logic [AddrWidth-1:0] c_q_addr,
    output logic [31:0]          c_q_data_op,
    output logic [DataWidth-1:0] c_q_data_arga,
    output logic [DataWidth-1:0] c_q_data_argb,
    output logic [DataWidth-1:0] c_q_data_argc,
    output logic [IdWidth-1:0]   c_q_id,
    output logic                 c_q_valid,
    input  logic                 c_q_ready,
    input  logic [DataWidth-1:0] c_p_data0,
    input  logic [DataWidth-1:0] c_p_data1,
    input  logic                 c_p_dual_writeback,
    input  logic                 c_p_error,
    input  logic [IdWidth-1:0]   c_p_id,
    input  logic [4:0]           c_p_rd,
    input  logic                 c_p_valid,
    output logic                 c_p_ready
);

    logic                 c_q_valid_q, c_q_valid_d;
    logic [31:0]          op_q, op_d;
    logic [DataWidth-1:0] arga_q, arga_d, argb_q, argb_d, argc_q, argc_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [IdWidth-1:0]   id_cnt_q, id_cnt_d;

    logic hazard_c;
    logic ops_ok_c;
    logic reg_free_c;
    logic take_c;
    logic unused_c_p_id;

    // Predecoder passthrough and response passthrough (ID not forwarded)
    assign prd_q_instr_data   = x_q_instr_data;
    assign x_k_accept         = prd_p_accept;
    assign x_k_writeback      = prd_p_writeback;
    assign x_p_data0          = c_p_data0;
    assign x_p_data1          = c_p_data1;
    assign x_p_dual_writeback = c_p_dual_writeback;
    assign x_p_error          = c_p_error;
    assign x_p_rd             = c_p_rd;
    assign x_p_valid          = c_p_valid;
    assign c_p_ready          = x_p_ready;
    assign unused_c_p_id      = ^c_p_id;

`ifdef ACC_X_ADAPTER_HAZARD_EN
    acc_issue_t issue_c;
    acc_rsp_t   rsp_c;

    always_comb begin
        issue_c.rd        = reg_field(x_q_instr_data, RdLsb);
        issue_c.writeback = prd_p_writeback;
        rsp_c.rd          = c_p_rd;
        rsp_c.dual        = c_p_dual_writeback;
    end

    acc_x_scoreboard u_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .set_valid_i (take_c),
        .set_i       (issue_c),
        .clr_valid_i (c_p_valid && x_p_ready),
        .clr_i       (rsp_c),
        .instr_i     (x_q_instr_data),
        .use_rs_i    (prd_p_use_rs),
        .writeback_i (prd_p_writeback),
        .hazard_o    (hazard_c)
    );
`else
    assign hazard_c = 1'b0;
`endif

    // Rejected instructions are consumed at once; accepted ones wait for
    // operands, a free (or draining) output slot and a clean scoreboard
    always_comb begin
        ops_ok_c   = &(~prd_p_use_rs | x_q_rs_valid);
        reg_free_c = !c_q_valid_q || c_q_ready;
        x_q_ready  = !prd_p_accept || (ops_ok_c && reg_free_c && !hazard_c);
        take_c     = x_q_valid && prd_p_accept && x_q_ready;
    end

    // Single-entry request holding register plus issue ID counter
    always_comb begin
        c_q_valid_d = c_q_valid_q;
        op_d        = op_q;
        arga_d      = arga_q;
        argb_d      = argb_q;
        argc_d      = argc_q;
        id_d        = id_q;
        id_cnt_d    = id_cnt_q;
        if (take_c) begin
            c_q_valid_d = 1'b1;
            op_d        = x_q_instr_data;
            arga_d      = x_q_rs1;
            argb_d      = x_q_rs2;
            argc_d      = x_q_rs3;
            id_d        = id_cnt_q;
            id_cnt_d    = id_cnt_q + IdWidth'(1);
        end else if (c_q_ready) begin
            c_q_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_q_valid_q <= 1'b0;
            op_q        <= '0;
            arga_q      <= '0;
            argb_q      <= '0;
            argc_q      <= '0;
            id_q        <= '0;
            id_cnt_q    <= '0;
        end else begin
            c_q_valid_q <= c_q_valid_d;
            op_q        <= op_d;
            arga_q      <= arga_d;
            argb_q      <= argb_d;
            argc_q      <= argc_d;
            id_q        <= id_d;
            id_cnt_q    <= id_cnt_d;
        end
    end

    assign c_q_valid     = c_q_valid_q;
    assign c_q_data_op   = op_q;
    assign c_q_data_arga = arga_q;
    assign c_q_data_argb = argb_q;
    assign c_q_data_argc = argc_q;
    assign c_q_id        = id_q;
    assign c_q_addr      = AddrWidth'(AccAddr);

endmodule

// File: doc/acc_x_adapter.md
ACC_X_ADAPTER -- requirements
Module: acc_x_adapter

Interface
REQ-001 SHALL have parameters, one per line: DataWidth, 32, operand/result width; AddrWidth, 2, C-bus address width; IdWidth, 4, C-bus transaction ID width; AccAddr, 0, fixed C-bus target address.
REQ-002 SHALL have one clock, clk_i, and an asynchronous active-low reset, rst_ni.
REQ-003 Ports, one per line (name, direction, width, meaning):
 clk_i  in  1  clock
 rst_ni  in  1  async active-low reset
 x_q_instr_data  in  32  offloaded instruction
 x_q_rs1/x_q_rs2/x_q_rs3  in  DataWidth  operands
 x_q_rs_valid  in  3  operand valid flags
 x_q_valid  in  1  X request valid
 x_q_ready  out  1  X request handshake
 x_k_accept  out  1  instruction accepted
 x_k_writeback  out  2  writeback expected (bit0 rd, bit1 rd|1)
 x_p_data0/x_p_data1  out  DataWidth  results
 x_p_dual_writeback, x_p_error  out  1  response flags
 x_p_rd  out  5  destination register
 x_p_valid  out  1 / x_p_ready  in  1  response handshake
 prd_q_instr_data  out  32 / prd_p_accept  in  1 / prd_p_writeback  in  2 / prd_p_use_rs  in  3  predecoder
 c_q_addr  out  AddrWidth / c_q_data_op  out  32 / c_q_data_arga/argb/argc  out  DataWidth / c_q_id  out  IdWidth
 c_q_valid  out  1 / c_q_ready  in  1  C request handshake
 c_p_data0/c_p_data1  in  DataWidth / c_p_dual_writeback, c_p_error  in  1 / c_p_id  in  IdWidth / c_p_rd  in  5
 c_p_valid  in  1 / c_p_ready  out  1  C response handshake

Function
REQ-004 prd_q_instr_data SHALL equal x_q_instr_data combinationally; x_k_accept = prd_p_accept, x_k_writeback = prd_p_writeback.
REQ-005 Rejected instruction (x_q_valid, !prd_p_accept): x_q_ready SHALL be 1 same cycle; nothing issued.
REQ-006 Accepted instruction SHALL be taken (x_q_ready=1) iff all operands flagged in prd_p_use_rs have x_q_rs_valid set, the output register is empty or draining (c_q_ready) this cycle, and no hazard (REQ-010).
REQ-007 Output register: one entry; on take, c_q_valid=1 next cycle with op, args (rs1/2/3), addr=AccAddr, id=current counter; contents SHALL stay stable until c_q_valid&&c_q_ready; back-to-back issue at one per cycle SHALL be supported.
REQ-008 ID counter SHALL increment by 1 per take, wrapping 2^IdWidth-1 -> 0.
REQ-009 Scoreboard: 32 pending bits; on take, writeback[0] sets pending[rd=instr[11:7]], writeback[1] sets pending[rd|1]; x0 never set; c_p_valid&&c_p_ready clears pending[c_p_rd], and pending[c_p_rd|1] if c_p_dual_writeback.
REQ-010 Hazard SHALL be: any used source (rs1=[19:15], rs2=[24:20], rs3=[31:27]) or any written destination pending, evaluated on registered state (clear visible next cycle, no bypass).
REQ-011 Response path SHALL be combinational pass-through: x_p_* = c_p_* (id dropped), c_p_ready = x_p_ready.
REQ-012 Same-cycle set and clear of different bits SHALL both take effect.

Reset
REQ-013 On rst_ni low: c_q_valid=0, ID counter=0, all pending=0; x_q_ready, x_p_valid follow combinational inputs; reset mid-transaction SHALL discard the held request.

Configuration
REQ-014 Macro ACC_X_ADAPTER_HAZARD_EN defined: scoreboard and hazard stall active; undefined: no scoreboard flops, hazard constantly 0.

Structure
REQ-015 Package acc_pkg SHALL hold the request/response struct typedefs and register-field index constants.
REQ-016 Scoreboard SHALL be sub-module acc_x_scoreboard.

Verification
REQ-017 Reject: instr 0x00000013, prd_p_accept=0 -> x_q_ready=1, x_k_accept=0, no c_q_valid.
REQ-018 Operand wait: use_rs=3'b011, rs_valid=3'b001 -> x_q_ready=0; rs_valid=3'b011 -> take; next cycle c_q_valid=1, arga/argb match, id=0.
REQ-019 Backpressure: c_q_ready=0 for 5 cycles -> C request fields stable, second X request stalled; c_q_ready=1 -> both issued, ids 0,1.
REQ-020 RAW hazard (HAZARD_EN): issue rd=5 with writeback 01, then instr reading rs1=5 -> stalled until c_p handshake rd=5, taken cycle after.
REQ-021 ID wrap: 17 issues with IdWidth=4 -> 17th c_q_id=0.
REQ-022 Reset with c_q_valid=1 pending -> c_q_valid=0, pending=0 after release.
